// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencing controller:
// FSM states, opcode constants and trap cause codes.
package seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_TIMEOUT = 2'b10;

endpackage

// File: rtl/seq_perf_counters.sv
// Free-running activity and retirement counters for the sequencer.
// Only instantiated when SEQ_PERF_EN is defined.
module seq_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic        retire,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
);

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (active) cycle_count   <= cycle_count + 32'd1;
            if (retire) retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle fetch/decode/exec/writeback sequencer with halt and trap.
// Define SEQ_PERF_EN to add cycle_count / retired_count outputs.
module seq_controller
    import seq_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 15,
    parameter int EXEC_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        trap_clear,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] inst_code,
    output logic [31:0] ir,
    output logic        pc_en,
    output logic        write_on_register,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
`ifdef SEQ_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] retired_count
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);
    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt;
    logic [3:0] exec_cnt;
    logic       fetch_expired;
    logic [6:0] opcode;

    assign state         = state_q;
    assign opcode        = ir[6:0];
    assign fetch_expired = (wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection; a ready fetch beats the timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready)         state_d = S_DECODE;
                else if (fetch_expired) state_d = S_TRAP;
            end
            S_DECODE: begin
                if (opcode == OP_RTYPE)       state_d = S_EXEC;
                else if (opcode == OP_SYSTEM) state_d = S_HALT;
                else                          state_d = S_TRAP;
            end
            S_EXEC:   if (exec_cnt == EXEC_LAST) state_d = S_WB;
            S_WB:     state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            S_TRAP:   if (trap_clear) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Instruction register, wait/exec counters and trap cause.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir         <= '0;
            wait_cnt   <= '0;
            exec_cnt   <= '0;
            trap_cause <= TC_NONE;
        end else begin
            if (state_q == S_FETCH && imem_ready) ir <= inst_code;

            if (state_q == S_FETCH && !imem_ready)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;

            if (state_q == S_EXEC && state_d == S_EXEC)
                exec_cnt <= exec_cnt + 4'd1;
            else
                exec_cnt <= '0;

            if (state_q == S_FETCH && !imem_ready && fetch_expired)
                trap_cause <= TC_TIMEOUT;
            else if (state_q == S_DECODE && state_d == S_TRAP)
                trap_cause <= TC_ILLEGAL;
            else if (state_q == S_TRAP && trap_clear)
                trap_cause <= TC_NONE;
        end
    end

    // Moore outputs, forced quiet while reset is asserted.
    always_comb begin
        imem_req          = 1'b0;
        pc_en             = 1'b0;
        write_on_register = 1'b0;
        halted            = 1'b0;
        trap              = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: imem_req = 1'b1;
                S_WB: begin
                    pc_en             = 1'b1;
                    write_on_register = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                S_TRAP:  trap   = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQ_PERF_EN
    logic perf_active;
    assign perf_active = !(state_q == S_IDLE ||
                           state_q == S_HALT ||
                           state_q == S_TRAP);

    seq_perf_counters u_perf (
        .clk           (clk),
        .reset         (reset),
        .active        (perf_active),
        .retire        (state_q == S_WB),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );
`endif

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter FETCH_TIMEOUT, default 15: max wait cycles in FETCH without imem_ready before trap (range 1..255).
REQ-002 Parameter EXEC_CYCLES, default 1: cycles spent in EXEC per instruction (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; 1 = keep issuing instructions.
REQ-006 trap_clear  input  1  pulse; leaves TRAP.
REQ-007 imem_req  output  1  fetch request to instruction memory.
REQ-008 imem_ready  input  1  fetch complete; inst_code valid this cycle.
REQ-009 inst_code  input  32  instruction from memory.
REQ-010 ir  output  32  captured instruction register, drives control_block/datapath fields.
REQ-011 pc_en  output  1  one-cycle PC-advance strobe.
REQ-012 write_on_register  output  1  one-cycle register-file write strobe.
REQ-013 halted  output  1  1 while in HALT.
REQ-014 trap  output  1  1 while in TRAP.
REQ-015 trap_cause  output  2  00 none, 01 illegal opcode, 10 fetch timeout.
REQ-016 state  output  3  current FSM state encoding (debug).

Function
REQ-017 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5, TRAP=6; encoding 7 unreachable, recovers to IDLE next cycle.
REQ-018 IDLE: run=1 -> FETCH next cycle; else stay.
REQ-019 FETCH: imem_req=1 combinationally; imem_ready=1 -> ir<=inst_code, go DECODE; else increment wait counter.
REQ-020 FETCH: wait counter reaching FETCH_TIMEOUT with imem_ready=0 -> TRAP, trap_cause=10; imem_ready=1 in that same cycle wins (normal capture).
REQ-021 imem_ready outside FETCH SHALL be ignored; ir holds.
REQ-022 DECODE (1 cycle): ir[6:0]=0110011 -> EXEC; ir[6:0]=1110011 -> HALT; any other -> TRAP, trap_cause=01.
REQ-023 EXEC: remain exactly EXEC_CYCLES cycles, then WB.
REQ-024 WB (1 cycle): write_on_register=1 and pc_en=1; next state FETCH if run=1, else IDLE.
REQ-025 run deassertion mid-instruction SHALL NOT abort; current instruction completes through WB.
REQ-026 Fetch-to-writeback latency with zero-wait memory SHALL be 3+EXEC_CYCLES cycles (FETCH, DECODE, EXEC..., WB).
REQ-027 HALT: absorbing; only reset exits; pc_en, write_on_register, imem_req held 0.
REQ-028 TRAP: trap=1, trap_cause held; trap_clear=1 -> IDLE and trap_cause<=00; strobes held 0.
REQ-029 pc_en and write_on_register SHALL never assert outside WB.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=IDLE, ir=0, trap_cause=00, counters=0, regardless of current state; outstanding fetch dropped.
REQ-031 During/after reset: imem_req=0, pc_en=0, write_on_register=0, halted=0, trap=0.
REQ-032 reset SHALL take priority over run, trap_clear and imem_ready in the same cycle.

Configuration
REQ-033 Macro SEQ_PERF_EN defined: add outputs cycle_count[31:0] (increments every non-reset cycle outside IDLE/HALT/TRAP) and retired_count[31:0] (increments each WB); both wrap at 2^32, clear on reset.
REQ-034 SEQ_PERF_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-035 Package seq_pkg SHALL hold state encodings, opcode constants (OP_RTYPE=0110011, OP_SYSTEM=1110011) and trap_cause codes.
REQ-036 Counters of REQ-033 SHALL live in sub-module seq_perf_counters, instantiated only under SEQ_PERF_EN.

Verification
REQ-037 R-type 0x002081B3 with imem_ready same cycle as request, EXEC_CYCLES=1 -> write_on_register and pc_en pulse once, 4 cycles after FETCH entry.
REQ-038 imem_ready held 0 with FETCH_TIMEOUT=15 -> trap=1, trap_cause=10 after 15 FETCH cycles; trap_clear -> IDLE, cause 00.
REQ-039 inst_code 0x00000013 (I-type) -> TRAP, trap_cause=01, no write strobe; 0x00000073 -> halted=1, stays until reset.
REQ-040 run dropped during EXEC -> WB strobes still occur once, then IDLE; no new imem_req.
REQ-041 reset asserted in EXEC -> next cycle state=IDLE, ir=0, no WB strobe.
REQ-042 SEQ_PERF_EN, 3 back-to-back R-type, zero-wait -> retired_count=3, cycle_count=12.
